imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion to the byte-addressed instruction memory. Accepts 32-bit
//  instruction words over a valid/ready stream and writes them as 4 little-endian
//  byte writes to the instruction memory's write port, starting at BASE_ADDR.
//  Holds the CPU stalled while loading and reports completion or overflow.
// PARAMETERS
//  MEM_BYTES  1024  instruction memory depth in bytes
//  ADDR_W     64    width of mem_addr; matches the fetch address width
//  BASE_ADDR  0     first byte address written after start
// PORTS
//  clk          in   1       single clock; all state changes on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       1-cycle pulse; begins a load at BASE_ADDR
//  word_in      in   32      instruction word; bits [7:0] go to the lowest address
//  word_valid   in   1       word_in is valid
//  word_last    in   1       qualifies word_in as the final word of the image
//  word_ready   out  1       loader accepts word_in this cycle
//  mem_we       out  1       byte write strobe to the instruction memory
//  mem_addr     out  ADDR_W  byte address of the write
//  mem_wdata    out  8       byte to write
//  busy         out  1       load in progress; also used as the CPU stall/hold
//  done         out  1       sticky: image loaded; cleared by start
//  overflow     out  1       sticky: word would exceed MEM_BYTES; cleared by start
//  words_loaded out  16      count of words fully written since the last start
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE. All outputs are 0. Byte pointer = BASE_ADDR.
//  - States are IDLE, ACCEPT, WRITE, DONE and ERR. The 2-bit lane counter is used in WRITE.
//  - IDLE/DONE/ERR: start=1 -> ACCEPT, pointer=BASE_ADDR, words_loaded=0,
//    and done and overflow are cleared. Other inputs are ignored.
//  - ACCEPT: word_ready=1 and busy=1. A transfer is word_valid & word_ready. The word and
//    word_last are registered.
//    - If pointer+4 > MEM_BYTES: go to ERR, overflow=1, and make no writes.
//    - Otherwise go to WRITE with lane=0.
//  - WRITE: word_ready=0, mem_we=1, mem_addr=pointer+lane, and
//    mem_wdata=word[8*lane+7:8*lane]. The lane increments once per cycle.
//    - After lane 3: pointer+=4 and words_loaded+=1.
//    - Then go to DONE if last, else to ACCEPT.
//  - Timing: a word accepted in cycle N produces byte writes in N+1..N+4.
//    word_ready returns in N+5. Throughput is 1 word per 5 cycles.
//  - mem_we is registered. It is never asserted outside WRITE.
//  - DONE: busy=0 and done=1. ERR: busy=0 and overflow=1. Both hold until start.
//  - start while busy (ACCEPT/WRITE) is ignored. An in-flight word always completes all 4 bytes.
//  - word_valid without start (in IDLE) is ignored, and word_ready stays 0.
//  - Exact fill is legal: a word ending at byte MEM_BYTES-1 is written.
//    The next word raises overflow.
//  - rst_n asserted mid-WRITE: mem_we drops immediately (async). The partial word is abandoned.
//  - Pointer arithmetic is ADDR_W bits and never wraps, because the overflow check precedes the write.
//  - words_loaded saturates at 16'hFFFF.
// STRUCTURE
//  - Shared package: state encoding (IDLE/ACCEPT/WRITE/DONE/ERR), BYTES_PER_WORD=4,
//    LANE_W=2. The memory write-port bundle widths are shared with the memory.
//  - One natural sub-module: imem_byte_serializer. It takes a 32-bit word plus a go
//    pulse and emits 4 sequential byte/lane strobes. The FSM and counters stay in imem_loader.
// TESTING
//  1. Reset: hold rst_n=0 with clk running -> all outputs 0 and word_ready=0. Release -> still IDLE.
//  2. Single word: start, then word_in=32'h00100613 with last=1 -> writes at addr 0..3 of
//     13,06,10,00 on 4 consecutive cycles. Then done=1, words_loaded=1, busy=0.
//  3. Stream: 21 words, last on the 21st, with valid gaps -> 84 byte writes at addr 0..83,
//     little-endian. Readback via the instruction memory matches every word. words_loaded=21.
//  4. Overflow with MEM_BYTES=8: send 3 words, no last -> words 0-1 are written to 0..7.
//     The 3rd sets overflow=1 with no mem_we. Then start -> overflow=0.
//  5. Collisions: start pulsed during WRITE is ignored. rst_n dropped at lane 2 -> mem_we=0
//     at once, and after release state=IDLE.
//  6. Restart: after done, a new start and 1 word 32'hFFFFFFFF -> written again at BASE_ADDR.
//     done re-asserts and words_loaded=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and widths.
// Write-port widths are shared with the instruction memory.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    typedef logic [LANE_W-1:0] lane_t;

    // Little-endian lane select: lane 0 is bits [7:0].
    function automatic logic [BYTE_W-1:0] lane_byte(
        input logic [WORD_W-1:0] w,
        input lane_t             l
    );
        return w[l*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Word stream in, byte write port out.
// The loader is the slave; the producer side is the master.
interface imem_loader_if #(
    parameter int ADDR_W = 64
);
    import imem_loader_pkg::*;

    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_last;
    logic              word_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTE_W-1:0] mem_wdata;

    modport master (
        output word_in, word_valid, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  word_in, word_valid, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_byte_serializer.sv
// Turns one latched word into 4 sequential byte strobes.
// Strobe is a flop so async reset kills it at once.
module imem_byte_serializer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [WORD_W-1:0] word,
    output logic              active,
    output lane_t             lane,
    output logic [BYTE_W-1:0] data,
    output logic              last_lane
);

    logic [WORD_W-1:0] word_q;

    // Latch the word on go, then step lanes 0..3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            lane   <= '0;
            active <= 1'b0;
        end else if (go) begin
            word_q <= word;
            lane   <= '0;
            active <= 1'b1;
        end else if (active) begin
            lane <= lane + 1'b1;
            if (lane == '1)
                active <= 1'b0;
        end
    end

    assign data      = lane_byte(word_q, lane);
    assign last_lane = active && (lane == '1);

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit words into byte-wide instruction memory.
// Holds the CPU (busy) while loading; flags done/overflow.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int              MEM_BYTES = 1024,
    parameter int              ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    imem_loader_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] words_loaded
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              last_q;
    logic              ready;
    logic              xfer;
    logic              fits;
    logic              restart;
    logic              go;
    logic              ser_active;
    lane_t             ser_lane;
    logic [BYTE_W-1:0] ser_data;
    logic              ser_last;

    assign xfer    = bus.word_valid && ready;
    assign fits    = (ptr + ADDR_W'(BYTES_PER_WORD))
                     <= ADDR_W'(MEM_BYTES);
    assign go      = xfer && fits;
    assign restart = start && !busy;

    imem_byte_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .word      (bus.word_in),
        .active    (ser_active),
        .lane      (ser_lane),
        .data      (ser_data),
        .last_lane (ser_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start)
                    state_nxt = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (xfer)
                    state_nxt = fits ? S_WRITE : S_ERR;
            end
            S_WRITE: begin
                if (ser_last)
                    state_nxt = last_q ? S_DONE : S_ACCEPT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        overflow = 1'b0;
        unique case (state)
            S_ACCEPT: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
            S_WRITE: busy     = 1'b1;
            S_DONE:  done     = 1'b1;
            S_ERR:   overflow = 1'b1;
            default: ;
        endcase
    end

    // Byte pointer, word count and last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= BASE_ADDR;
            words_loaded <= '0;
            last_q       <= 1'b0;
        end else if (restart) begin
            ptr          <= BASE_ADDR;
            words_loaded <= '0;
            last_q       <= 1'b0;
        end else begin
            if (xfer)
                last_q <= bus.word_last;
            if (ser_last) begin
                ptr <= ptr + ADDR_W'(BYTES_PER_WORD);
                if (words_loaded != '1)
                    words_loaded <= words_loaded + 1'b1;
            end
        end
    end

    assign bus.word_ready = ready;
    assign bus.mem_we     = ser_active;
    assign bus.mem_addr   = ser_active ? ptr + ADDR_W'(ser_lane) : '0;
    assign bus.mem_wdata  = ser_active ? ser_data : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader.
// Reference image is built from word index arithmetic.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int MEM = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] words_loaded;

    imem_loader_if #(.ADDR_W(64)) bus ();

    imem_loader #(
        .MEM_BYTES (MEM),
        .ADDR_W    (64),
        .BASE_ADDR (64'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] dmem    [MEM];
    logic [7:0] exp_img [MEM];
    int wr_count = 0;
    int oob      = 0;
    int viol     = 0;

    // Log every byte write seen on the memory port.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (bus.mem_addr < 64'(MEM))
                dmem[bus.mem_addr[9:0]] = bus.mem_wdata;
            else
                oob++;
            wr_count++;
            if (bus.word_ready || !busy)
                viol++;
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < MEM; i++) begin
            dmem[i]    = 8'h00;
            exp_img[i] = 8'h00;
        end
        wr_count = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Model: word k of a load lands at bytes 4k..4k+3, LSB first.
    task automatic model_word(input int k, input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            exp_img[4*k+i] = 8'((w >> (8*i)) & 32'hFF);
    endtask

    task automatic send_word(input logic [31:0] w,
                             input bit last,
                             input int gap);
        int n;
        repeat (gap) step();
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        bus.word_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.word_ready) break;
            n++;
            if (n > 50) begin
                check("ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        step();
        bus.word_valid = 1'b0;
        bus.word_last  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 50) begin
                check({tag, "_timeout"}, 64'd0, 64'd1);
                break;
            end
        end
        step();
    endtask

    task automatic check_img(input string tag, input int nbytes);
        int diff;
        diff = 0;
        for (int i = 0; i < nbytes; i++)
            if (dmem[i] !== exp_img[i]) diff++;
        check(tag, 64'(diff), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  b2 [4];
        b2[0] = 8'h13;
        b2[1] = 8'h06;
        b2[2] = 8'h10;
        b2[3] = 8'h00;
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        bus.word_last  = 1'b0;
        clear_log();

        // 1. Reset held with clock running.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.word_ready), 0);
        check("rst_we",    64'(bus.mem_we), 0);
        check("rst_addr",  bus.mem_addr, 0);
        check("rst_wdata", 64'(bus.mem_wdata), 0);
        check("rst_busy",  64'(busy), 0);
        check("rst_flags", 64'({done, overflow}), 0);
        check("rst_wl",    64'(words_loaded), 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("rel_busy",  64'(busy), 0);
        check("rel_ready", 64'(bus.word_ready), 0);

        // 2. Single word, cycle-exact byte writes.
        pulse_start();
        w = 32'h0010_0613;
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        bus.word_last  = 1'b1;
        @(negedge clk);
        check("s_ready", 64'(bus.word_ready), 1);
        check("s_busy",  64'(busy), 1);
        step();
        bus.word_valid = 1'b0;
        bus.word_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("s_we%0d", i),   64'(bus.mem_we), 1);
            check($sformatf("s_addr%0d", i), bus.mem_addr, 64'(i));
            check($sformatf("s_data%0d", i), 64'(bus.mem_wdata),
                  64'(b2[i]));
            check($sformatf("s_nrdy%0d", i), 64'(bus.word_ready), 0);
        end
        @(negedge clk);
        check("s_we_off", 64'(bus.mem_we), 0);
        check("s_done",   64'(done), 1);
        check("s_busy0",  64'(busy), 0);
        check("s_wl",     64'(words_loaded), 1);
        step();

        // 3. 21-word stream with random valid gaps.
        clear_log();
        pulse_start();
        check("st_done_clr", 64'(done), 0);
        for (int k = 0; k < 21; k++) begin
            w = $urandom;
            model_word(k, w);
            send_word(w, k == 20, int'($urandom_range(0, 3)));
        end
        wait_idle("st_idle");
        check("st_count", 64'(wr_count), 84);
        check_img("st_img", 84);
        check("st_wl",   64'(words_loaded), 21);
        check("st_done", 64'(done), 1);

        // 4. Exact fill of all 1024 bytes, then overflow.
        clear_log();
        pulse_start();
        for (int k = 0; k < MEM / 4; k++) begin
            w = $urandom;
            model_word(k, w);
            send_word(w, 1'b0, int'($urandom_range(0, 1)));
        end
        repeat (5) step();
        check("fill_wl",    64'(words_loaded), 256);
        check("fill_count", 64'(wr_count), 1024);
        check("fill_ready", 64'(bus.word_ready), 1);
        check("fill_ovf",   64'(overflow), 0);
        check_img("fill_img", MEM);
        send_word($urandom, 1'b0, 0);
        check("ovf_flag",  64'(overflow), 1);
        check("ovf_busy",  64'(busy), 0);
        check("ovf_done",  64'(done), 0);
        repeat (4) step();
        check("ovf_nowr",  64'(wr_count), 1024);
        check("ovf_wl",    64'(words_loaded), 256);
        check("ovf_hold",  64'(overflow), 1);
        pulse_start();
        check("ovf_clr",   64'(overflow), 0);
        check("ovf_rbusy", 64'(busy), 1);
        check("ovf_rwl",   64'(words_loaded), 0);
        send_word(32'h1234_5678, 1'b1, 0);
        wait_idle("ovf_idle");
        check("ovf_rdone", 64'(done), 1);

        // 5. start during WRITE ignored; reset mid-word.
        clear_log();
        pulse_start();
        send_word(32'hA1B2_C3D4, 1'b0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("col_ready", 64'(bus.word_ready), 1);
        check("col_wl",    64'(words_loaded), 1);
        check("col_count", 64'(wr_count), 4);
        check("col_b0",    64'(dmem[0]), 64'hD4);
        check("col_b3",    64'(dmem[3]), 64'hA1);
        send_word(32'h5566_7788, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_we",   64'(bus.mem_we), 1);
        check("mid_addr", bus.mem_addr, 6);
        rst_n = 1'b0;
        #1;
        check("mid_we0",  64'(bus.mem_we), 0);
        check("mid_busy", 64'(busy), 0);
        check("mid_wl",   64'(words_loaded), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("mid_idle", 64'({busy, done, overflow}), 0);
        check("mid_part", 64'(wr_count), 6);
        bus.word_in    = 32'hDEAD_BEEF;
        bus.word_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_nrdy", 64'(bus.word_ready), 0);
        end
        step();
        bus.word_valid = 1'b0;
        check("idle_nowr", 64'(wr_count), 6);

        // 6. Restart writes again at the base address.
        clear_log();
        pulse_start();
        model_word(0, 32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF, 1'b1, 0);
        wait_idle("rs_idle");
        check("rs_count", 64'(wr_count), 4);
        check_img("rs_img", 4);
        check("rs_done",  64'(done), 1);
        check("rs_wl",    64'(words_loaded), 1);

        check("no_oob",   64'(oob), 0);
        check("we_rules", 64'(viol), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
